// File: rtl/hls_stream_engine_pkg.sv
// Shared types and constants for the HLS stream engine control/completion tracker.
package hls_stream_engine_pkg;

   localparam int unsigned DEF_N_IN  = 2;
   localparam int unsigned DEF_N_OUT = 1;
   localparam int unsigned DEF_CNT_W = 16;
   localparam int unsigned DEF_TO_W  = 16;

   localparam int unsigned STATE_W = 2;
   typedef logic [STATE_W-1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_DONE = 2'd2;
   localparam state_t ST_ERR  = 2'd3;

   typedef logic [1:0] err_code_t;

   localparam err_code_t ERR_NONE     = 2'b00;
   localparam err_code_t ERR_TIMEOUT  = 2'b01;
   localparam err_code_t ERR_OVERFLOW = 2'b10;

endpackage

// File: rtl/hls_stream_cnt.sv
// One monitored stream channel: captures length/enable at job start, counts handshakes,
// flags completion and handshakes beyond the programmed length.
module hls_stream_cnt
   import hls_stream_engine_pkg::*;
#(
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             load_i,
   input  logic             run_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] len_i,
   input  logic             valid_i,
   input  logic             ready_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             done_nxt_c_o,
   output logic             inc_c_o,
   output logic             ovf_c_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic             en_q, en_d;
   logic             hs;
   logic             full;

   assign hs   = valid_i & ready_i;
   assign full = (cnt_q == len_q);

   // A beat arriving when already full is an overflow and never increments, so no wrap.
   assign inc_c_o = run_i & en_q & hs & ~full;
   assign ovf_c_o = run_i & en_q & hs & full;

   always_comb begin
      cnt_d = cnt_q;
      len_d = len_q;
      en_d  = en_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = '0;
         len_d = len_i;
         en_d  = en_i;
      end else if (inc_c_o) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Completion as seen next cycle, so the top can register its reductions.
   assign done_nxt_c_o = (cnt_d == len_d) | ~en_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         len_q <= '0;
         en_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         len_q <= len_d;
         en_q  <= en_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/hls_stream_engine_ctrl.sv
// Control and completion tracker for an HLS streaming datapath: ap_start/ready/done/idle
// generation, per-channel transfer counting, stall watchdog and overflow detection.
module hls_stream_engine_ctrl
   import hls_stream_engine_pkg::*;
#(
   parameter int unsigned N_IN  = DEF_N_IN,
   parameter int unsigned N_OUT = DEF_N_OUT,
   parameter int unsigned CNT_W = DEF_CNT_W,
   parameter int unsigned TO_W  = DEF_TO_W
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        clear_i,
   input  logic                        start_i,
   input  logic [N_IN-1:0]             in_en_i,
   input  logic [N_OUT-1:0]            out_en_i,
   input  logic [N_IN-1:0][CNT_W-1:0]  in_len_i,
   input  logic [N_OUT-1:0][CNT_W-1:0] out_len_i,
   input  logic [TO_W-1:0]             timeout_i,
   input  logic [N_IN-1:0]             in_valid_i,
   input  logic [N_IN-1:0]             in_ready_i,
   input  logic [N_OUT-1:0]            out_valid_i,
   input  logic [N_OUT-1:0]            out_ready_i,
   output logic                        ap_start_o,
   output logic                        idle_o,
   output logic                        ready_o,
   output logic                        done_o,
   output logic                        err_o,
   output logic [1:0]                  err_code_o,
   output logic [N_IN-1:0][CNT_W-1:0]  in_cnt_o,
   output logic [N_OUT-1:0][CNT_W-1:0] out_cnt_o
);

   state_t          state_q, state_d;
   logic [TO_W-1:0] wd_q, wd_d;
   logic [TO_W-1:0] to_q, to_d;
   err_code_t       err_code_q, err_code_d;
   logic            src_done_q, src_done_d;
   logic            ap_start_q, ap_start_d;
   logic            idle_q, idle_d;
   logic            ready_q, ready_d;
   logic            done_q, done_d;
   logic            err_q, err_d;

   logic             run, load;
   logic [N_IN-1:0]  in_done_nxt, in_inc, in_ovf;
   logic [N_OUT-1:0] out_done_nxt, out_inc, out_ovf;
   logic             any_inc, any_ovf, to_evt;

   assign run  = (state_q == ST_RUN);
   assign load = (state_q == ST_IDLE) & start_i & ~clear_i;

   for (genvar i = 0; i < N_IN; i++) begin : g_in
      hls_stream_cnt #(.CNT_W(CNT_W)) u_cnt (
         .clk_i        (clk_i),
         .rst_ni       (rst_ni),
         .clear_i      (clear_i),
         .load_i       (load),
         .run_i        (run),
         .en_i         (in_en_i[i]),
         .len_i        (in_len_i[i]),
         .valid_i      (in_valid_i[i]),
         .ready_i      (in_ready_i[i]),
         .cnt_o        (in_cnt_o[i]),
         .done_nxt_c_o (in_done_nxt[i]),
         .inc_c_o      (in_inc[i]),
         .ovf_c_o      (in_ovf[i])
      );
   end

   for (genvar o = 0; o < N_OUT; o++) begin : g_out
      hls_stream_cnt #(.CNT_W(CNT_W)) u_cnt (
         .clk_i        (clk_i),
         .rst_ni       (rst_ni),
         .clear_i      (clear_i),
         .load_i       (load),
         .run_i        (run),
         .en_i         (out_en_i[o]),
         .len_i        (out_len_i[o]),
         .valid_i      (out_valid_i[o]),
         .ready_i      (out_ready_i[o]),
         .cnt_o        (out_cnt_o[o]),
         .done_nxt_c_o (out_done_nxt[o]),
         .inc_c_o      (out_inc[o]),
         .ovf_c_o      (out_ovf[o])
      );
   end

   // Only counted beats are progress; an overflowing beat can coincide with a timeout.
   assign any_inc = (|in_inc) | (|out_inc);
   assign any_ovf = (|in_ovf) | (|out_ovf);
   assign to_evt  = run & ~any_inc & (to_q != '0) & (wd_q == to_q - TO_W'(1));

   always_comb begin
      state_d    = state_q;
      wd_d       = wd_q;
      to_d       = to_q;
      err_code_d = err_code_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_RUN;
               wd_d    = '0;
               to_d    = timeout_i;
            end
         end
         ST_RUN: begin
            wd_d = (any_inc || to_q == '0) ? '0 : wd_q + TO_W'(1);
            if (any_ovf || to_evt) begin
               state_d = ST_ERR;
               if (to_evt)  err_code_d = err_code_d | ERR_TIMEOUT;
               if (any_ovf) err_code_d = err_code_d | ERR_OVERFLOW;
            end else if (src_done_q) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_ERR;
         default: state_d = ST_IDLE;
      endcase
      if (clear_i) begin
         state_d    = ST_IDLE;
         wd_d       = '0;
         err_code_d = ERR_NONE;
      end
      src_done_d = (state_d == ST_RUN) & (&out_done_nxt);
      ready_d    = (state_d == ST_RUN) & (&in_done_nxt);
      ap_start_d = (state_d == ST_RUN) & ~ready_d;
      idle_d     = (state_d == ST_IDLE);
      done_d     = (state_d == ST_DONE);
      err_d      = (state_d == ST_ERR);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         wd_q       <= '0;
         to_q       <= '0;
         err_code_q <= ERR_NONE;
         src_done_q <= 1'b0;
         ap_start_q <= 1'b0;
         idle_q     <= 1'b1;
         ready_q    <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wd_q       <= wd_d;
         to_q       <= to_d;
         err_code_q <= err_code_d;
         src_done_q <= src_done_d;
         ap_start_q <= ap_start_d;
         idle_q     <= idle_d;
         ready_q    <= ready_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign ap_start_o = ap_start_q;
   assign idle_o     = idle_q;
   assign ready_o    = ready_q;
   assign done_o     = done_q;
   assign err_o      = err_q;
   assign err_code_o = err_code_q;

endmodule

// File: tb/tb_hls_stream_engine_ctrl.sv
// Self-checking bench for hls_stream_engine_ctrl: directed vector table, corner sequences
// and randomized traffic compared against a job-level reference model.
module tb_hls_stream_engine_ctrl;

   localparam int unsigned N_IN  = 2;
   localparam int unsigned N_OUT = 1;
   localparam int unsigned CNT_W = 8;
   localparam int unsigned TO_W  = 8;

   logic                        clk_i, rst_ni, clear_i, start_i;
   logic [N_IN-1:0]             in_en_i;
   logic [N_OUT-1:0]            out_en_i;
   logic [N_IN-1:0][CNT_W-1:0]  in_len_i;
   logic [N_OUT-1:0][CNT_W-1:0] out_len_i;
   logic [TO_W-1:0]             timeout_i;
   logic [N_IN-1:0]             in_valid_i, in_ready_i;
   logic [N_OUT-1:0]            out_valid_i, out_ready_i;
   logic                        ap_start_o, idle_o, ready_o, done_o, err_o;
   logic [1:0]                  err_code_o;
   logic [N_IN-1:0][CNT_W-1:0]  in_cnt_o;
   logic [N_OUT-1:0][CNT_W-1:0] out_cnt_o;

   hls_stream_engine_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .CNT_W(CNT_W), .TO_W(TO_W)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
      .in_en_i(in_en_i), .out_en_i(out_en_i), .in_len_i(in_len_i), .out_len_i(out_len_i),
      .timeout_i(timeout_i), .in_valid_i(in_valid_i), .in_ready_i(in_ready_i),
      .out_valid_i(out_valid_i), .out_ready_i(out_ready_i), .ap_start_o(ap_start_o),
      .idle_o(idle_o), .ready_o(ready_o), .done_o(done_o), .err_o(err_o),
      .err_code_o(err_code_o), .in_cnt_o(in_cnt_o), .out_cnt_o(out_cnt_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: job phase 0 idle, 1 run, 2 done, 3 error.
   int       m_ph;
   int       m_ic[N_IN], m_il[N_IN], m_oc[N_OUT], m_ol[N_OUT];
   bit       m_ie[N_IN], m_oe[N_OUT];
   int       m_to, m_wd;
   bit [1:0] m_code;

   typedef struct {
      logic             start;
      logic [1:0]       in_en;
      logic [CNT_W-1:0] l0, l1, ol;
      logic [1:0]       ihs;
      logic             ohs;
      logic [6:0]       fl;    // {idle, ap_start, ready, done, err, code}
      logic [CNT_W-1:0] e0, e1, eo;
   } vec_t;

   localparam int NV = 16;
   vec_t tv[NV];

   function automatic vec_t mk(logic st, logic [1:0] en, int l0, int l1, int ol,
                               logic [1:0] ihs, logic ohs, logic [6:0] fl,
                               int e0, int e1, int eo);
      vec_t v;
      v.start = st;  v.in_en = en;
      v.l0 = CNT_W'(l0); v.l1 = CNT_W'(l1); v.ol = CNT_W'(ol);
      v.ihs = ihs; v.ohs = ohs; v.fl = fl;
      v.e0 = CNT_W'(e0); v.e1 = CNT_W'(e1); v.eo = CNT_W'(eo);
      return v;
   endfunction

   function automatic void model_reset();
      m_ph = 0; m_to = 0; m_wd = 0; m_code = 2'b00;
      for (int i = 0; i < N_IN; i++) begin m_ic[i] = 0; m_il[i] = 0; m_ie[i] = 0; end
      for (int o = 0; o < N_OUT; o++) begin m_oc[o] = 0; m_ol[o] = 0; m_oe[o] = 0; end
   endfunction

   function automatic void model_update();
      bit all_out, prog, ovf, tmo;
      if (clear_i) begin
         m_ph = 0; m_wd = 0; m_code = 2'b00;
         for (int i = 0; i < N_IN; i++) m_ic[i] = 0;
         for (int o = 0; o < N_OUT; o++) m_oc[o] = 0;
         return;
      end
      case (m_ph)
         0: if (start_i) begin
            m_ph = 1; m_wd = 0; m_to = int'(timeout_i);
            for (int i = 0; i < N_IN; i++) begin
               m_ic[i] = 0; m_il[i] = int'(in_len_i[i]); m_ie[i] = in_en_i[i];
            end
            for (int o = 0; o < N_OUT; o++) begin
               m_oc[o] = 0; m_ol[o] = int'(out_len_i[o]); m_oe[o] = out_en_i[o];
            end
         end
         1: begin
            all_out = 1; prog = 0; ovf = 0;
            for (int o = 0; o < N_OUT; o++)
               if (m_oe[o] && m_oc[o] != m_ol[o]) all_out = 0;
            for (int i = 0; i < N_IN; i++)
               if (m_ie[i] && in_valid_i[i] && in_ready_i[i]) begin
                  if (m_ic[i] == m_il[i]) ovf = 1;
                  else begin m_ic[i]++; prog = 1; end
               end
            for (int o = 0; o < N_OUT; o++)
               if (m_oe[o] && out_valid_i[o] && out_ready_i[o]) begin
                  if (m_oc[o] == m_ol[o]) ovf = 1;
                  else begin m_oc[o]++; prog = 1; end
               end
            tmo  = (m_to != 0) && !prog && (m_wd + 1 == m_to);
            m_wd = prog ? 0 : m_wd + 1;
            if (ovf || tmo) begin
               m_ph = 3; m_code = m_code | {ovf, tmo};
            end else if (all_out) begin
               m_ph = 2;
            end
         end
         2: m_ph = 0;
         default: ;
      endcase
   endfunction

   function automatic logic [63:0] model_vec();
      bit rdy;
      rdy = (m_ph == 1);
      for (int i = 0; i < N_IN; i++) if (m_ie[i] && m_ic[i] != m_il[i]) rdy = 0;
      return 64'({m_ph == 0, (m_ph == 1) && !rdy, rdy, m_ph == 2, m_ph == 3, m_code,
                  CNT_W'(m_ic[1]), CNT_W'(m_ic[0]), CNT_W'(m_oc[0])});
   endfunction

   function automatic logic [63:0] dut_vec();
      return 64'({idle_o, ap_start_o, ready_o, done_o, err_o, err_code_o,
                  in_cnt_o[1], in_cnt_o[0], out_cnt_o[0]});
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Inputs already applied; advance one clock and compare against the model.
   task automatic step();
      model_update();
      @(posedge clk_i);
      #1;
      chk("model", dut_vec(), model_vec());
   endtask

   task automatic cfg(input logic [1:0] en, input int l0, input int l1, input int ol,
                      input int to);
      in_en_i = en; out_en_i = 1'b1;
      in_len_i[0] = CNT_W'(l0); in_len_i[1] = CNT_W'(l1);
      out_len_i[0] = CNT_W'(ol); timeout_i = TO_W'(to);
   endtask

   task automatic quiet();
      start_i = 0; clear_i = 0;
      in_valid_i = '0; in_ready_i = '0; out_valid_i = '0; out_ready_i = '0;
   endtask

   initial begin
      rst_ni = 0;
      quiet();
      cfg(2'b11, 0, 0, 0, 0);
      model_reset();

      // lens {4,4}/{2}, full-rate beats
      tv[0]  = mk(1, 2'b11, 4, 4, 2, 2'b00, 0, 7'b0100000, 0, 0, 0);
      tv[1]  = mk(0, 2'b11, 4, 4, 2, 2'b11, 0, 7'b0100000, 1, 1, 0);
      tv[2]  = mk(0, 2'b11, 4, 4, 2, 2'b11, 0, 7'b0100000, 2, 2, 0);
      tv[3]  = mk(0, 2'b11, 4, 4, 2, 2'b11, 0, 7'b0100000, 3, 3, 0);
      tv[4]  = mk(0, 2'b11, 4, 4, 2, 2'b11, 0, 7'b0010000, 4, 4, 0);
      tv[5]  = mk(0, 2'b11, 4, 4, 2, 2'b00, 1, 7'b0010000, 4, 4, 1);
      tv[6]  = mk(0, 2'b11, 4, 4, 2, 2'b00, 1, 7'b0010000, 4, 4, 2);
      tv[7]  = mk(0, 2'b11, 4, 4, 2, 2'b00, 0, 7'b0001000, 4, 4, 2);
      tv[8]  = mk(0, 2'b11, 4, 4, 2, 2'b00, 0, 7'b1000000, 4, 4, 2);
      // ch0 disabled (len 0), ch1 len 3, out len 1
      tv[9]  = mk(1, 2'b10, 0, 3, 1, 2'b00, 0, 7'b0100000, 0, 0, 0);
      tv[10] = mk(0, 2'b10, 0, 3, 1, 2'b11, 0, 7'b0100000, 0, 1, 0);
      tv[11] = mk(0, 2'b10, 0, 3, 1, 2'b11, 0, 7'b0100000, 0, 2, 0);
      tv[12] = mk(0, 2'b10, 0, 3, 1, 2'b11, 0, 7'b0010000, 0, 3, 0);
      tv[13] = mk(0, 2'b10, 0, 3, 1, 2'b00, 1, 7'b0010000, 0, 3, 1);
      tv[14] = mk(0, 2'b10, 0, 3, 1, 2'b00, 0, 7'b0001000, 0, 3, 1);
      tv[15] = mk(0, 2'b10, 0, 3, 1, 2'b00, 0, 7'b1000000, 0, 3, 1);

      #12;
      chk("reset_vals", dut_vec(), 64'({7'b1000000, 24'h0}));
      rst_ni = 1;
      @(posedge clk_i); #1;

      for (int k = 0; k < NV; k++) begin
         start_i = tv[k].start; clear_i = 0;
         cfg(tv[k].in_en, int'(tv[k].l0), int'(tv[k].l1), int'(tv[k].ol), 0);
         in_valid_i = tv[k].ihs; in_ready_i = tv[k].ihs;
         out_valid_i = tv[k].ohs; out_ready_i = tv[k].ohs;
         step();
         chk($sformatf("vec%0d", k), dut_vec(), 64'({tv[k].fl, tv[k].e1, tv[k].e0, tv[k].eo}));
      end
      quiet();

      // Overflow together with final-source-done goes to ERR; start ignored; clear recovers.
      cfg(2'b00, 0, 0, 2, 0);
      start_i = 1; step(); start_i = 0;
      chk("allsink_ready", 64'({ready_o, ap_start_o}), 64'(2'b10));
      out_valid_i = 1; out_ready_i = 1;
      step(); step(); step();
      chk("ovf_err", 64'({err_o, err_code_o, done_o}), 64'(4'b1100));
      chk("ovf_cnt_held", 64'(out_cnt_o[0]), 64'(2));
      quiet(); start_i = 1; step(); start_i = 0;
      chk("ovf_start_ign", 64'({err_o, idle_o}), 64'(2'b10));
      clear_i = 1; step(); clear_i = 0;
      chk("ovf_clear", dut_vec(), 64'({7'b1000000, 24'h0}));

      // Watchdog: timeout 5, no beats -> error on the 6th RUN cycle.
      cfg(2'b11, 4, 4, 2, 5);
      start_i = 1; step(); start_i = 0;
      for (int c = 1; c <= 4; c++) begin
         step();
         chk($sformatf("to_wait%0d", c), 64'(err_o), 64'(0));
      end
      step();
      chk("to_err", 64'({err_o, err_code_o, ap_start_o}), 64'(4'b1010));
      start_i = 1; step(); start_i = 0;
      chk("to_start_ign", 64'({err_o, idle_o, err_code_o}), 64'(4'b1001));
      clear_i = 1; step(); clear_i = 0;
      chk("to_clear", 64'({idle_o, err_o}), 64'(2'b10));

      // Clear beats start; start during RUN neither restarts nor disturbs counting.
      cfg(2'b11, 4, 4, 2, 0);
      start_i = 1; clear_i = 1; step();
      chk("clr_over_start", 64'({idle_o, ap_start_o}), 64'(2'b10));
      clear_i = 0; step();
      start_i = 1; step(); start_i = 0;
      chk("job_start", 64'({idle_o, ap_start_o}), 64'(2'b01));
      in_valid_i = 2'b11; in_ready_i = 2'b11;
      step(); step();
      start_i = 1; cfg(2'b00, 1, 1, 1, 1); step(); start_i = 0;
      chk("run_start_ign", 64'({idle_o, in_cnt_o[0], in_cnt_o[1]}), 64'({1'b0, 8'd3, 8'd3}));
      step();
      chk("sink_ready", 64'({ready_o, ap_start_o}), 64'(2'b10));
      quiet(); out_valid_i = 1; out_ready_i = 1;
      step(); step();
      quiet(); step();
      chk("job_done", 64'({done_o, out_cnt_o[0]}), 64'({1'b1, 8'd2}));
      step();
      chk("job_idle", 64'({idle_o, done_o}), 64'(2'b10));

      // Maximum length: 255 beats complete, the 256th overflows with the counter held.
      cfg(2'b00, 0, 0, 255, 0);
      start_i = 1; step(); start_i = 0;
      out_valid_i = 1; out_ready_i = 1;
      for (int c = 0; c < 255; c++) step();
      chk("max_len_cnt", 64'({err_o, out_cnt_o[0]}), 64'({1'b0, 8'd255}));
      step();
      chk("max_len_ovf", 64'({err_o, err_code_o, out_cnt_o[0]}), 64'({3'b110, 8'd255}));
      quiet(); clear_i = 1; step(); clear_i = 0;

      // Asynchronous reset mid-job.
      cfg(2'b11, 8, 8, 4, 0);
      start_i = 1; step(); start_i = 0;
      in_valid_i = 2'b11; in_ready_i = 2'b11;
      step(); step(); step();
      chk("pre_rst_cnt", 64'(in_cnt_o[0]), 64'(3));
      #3 rst_ni = 0;
      #1;
      chk("async_rst", dut_vec(), 64'({7'b1000000, 24'h0}));
      model_reset();
      quiet();
      @(posedge clk_i); #2 rst_ni = 1;
      for (int c = 0; c < 4; c++) begin
         step();
         chk("no_done_after_rst", 64'(done_o), 64'(0));
      end

      // Randomized traffic; config inputs churn every cycle and must only matter at start.
      repeat (3000) begin
         start_i = ($urandom_range(0, 3) == 0);
         clear_i = (m_ph == 3) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 63) == 0);
         in_en_i = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
         for (int i = 0; i < N_IN; i++) in_len_i[i] = CNT_W'($urandom_range(0, 5));
         out_en_i = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
         out_len_i[0] = CNT_W'($urandom_range(0, 4));
         timeout_i = ($urandom_range(0, 2) == 0) ? '0 : TO_W'($urandom_range(2, 9));
         for (int i = 0; i < N_IN; i++) begin
            in_valid_i[i] = ((m_ic[i] < m_il[i]) || ($urandom_range(0, 15) == 0))
                            && ($urandom_range(0, 99) < 60);
            in_ready_i[i] = ($urandom_range(0, 99) < 70);
         end
         out_valid_i[0] = ((m_oc[0] < m_ol[0]) || ($urandom_range(0, 15) == 0))
                          && ($urandom_range(0, 99) < 60);
         out_ready_i[0] = ($urandom_range(0, 99) < 70);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/hls_stream_engine_ctrl.md
# hls_stream_engine_ctrl

Parametrised control and completion tracker for HLS-generated streaming datapaths inside an HWPE engine. It sits between the engine's control FSM and the HLS datapath and monitors N_IN sink and N_OUT source stream handshakes. Per-channel lengths and enables drive `ap_start`/`ready`/`done`/`idle` generation. It also provides a stall-timeout watchdog and detects handshakes beyond the programmed length.

## Interface
- `N_IN`, default 2: number of monitored sink (to-datapath) streams, ≥1
- `N_OUT`, default 1: number of monitored source (from-datapath) streams, ≥1
- `CNT_W`, default 16: transfer-counter and length width
- `TO_W`, default 16: watchdog counter width
- `clk_i` in 1: clock
- `rst_ni` in 1: reset, asynchronous, active-low
- `clear_i` in 1: synchronous soft clear, highest priority after reset
- `start_i` in 1: job start request from engine FSM (pulse or level)
- `in_en_i` in N_IN: per-sink enable mask; disabled channels count as done
- `out_en_i` in N_OUT: per-source enable mask
- `in_len_i` in N_IN×CNT_W: expected handshakes per sink
- `out_len_i` in N_OUT×CNT_W: expected handshakes per source
- `timeout_i` in TO_W: max consecutive RUN cycles without any handshake; 0 disables
- `in_valid_i`, `in_ready_i` in N_IN each: observed sink handshake signals
- `out_valid_i`, `out_ready_i` in N_OUT each: observed source handshake signals
- `ap_start_o` out 1: start to HLS datapath
- `idle_o` out 1: no job active
- `ready_o` out 1: all enabled sinks complete
- `done_o` out 1: one-cycle job-completion pulse
- `err_o` out 1: sticky error
- `err_code_o` out 2: 01 timeout, 10 overflow, 11 both
- `in_cnt_o` out N_IN×CNT_W, `out_cnt_o` out N_OUT×CNT_W: live counters

## Operation
- FSM states: IDLE, RUN, DONE, ERR. Reset state is IDLE.
- IDLE:
  - `idle_o`=1.
  - `start_i`=1 → RUN; all counters and the watchdog load 0.
  - Lengths and enables are sampled into internal registers on the start edge. Input changes during a job have no effect.
- RUN:
  - Each handshake (valid&ready) on an enabled channel increments its counter. Disabled channels never count.
  - Channel done = (cnt == len) or !en. A length of 0 is done immediately.
  - `ready_o` is the AND of all sink dones.
  - `ap_start_o`=1 from RUN entry until the first cycle `ready_o`=1, then 0 for the rest of the job.
  - All source dones true → DONE.
- DONE: `done_o`=1 for exactly one cycle → IDLE. `start_i` sampled in DONE is ignored.
- Overflow: a handshake on an enabled channel whose cnt==len leaves the counter held and sets err bit 1 → ERR.
- Watchdog:
  - Counts RUN cycles with no handshake on any enabled channel; resets to 0 on any handshake.
  - Reaching `timeout_i` (nonzero) sets err bit 0 → ERR.
- ERR: `err_o`=1 and `ap_start_o`=0. The state holds until `clear_i`; `start_i` is ignored.
- Simultaneous events:
  - Timeout and overflow in the same cycle set both code bits.
  - Overflow and final-source-done in the same cycle → ERR, not DONE.
- `clear_i` in any state: next state IDLE, counters, watchdog and error cleared. It overrides `start_i` in the same cycle.
- `start_i` while in RUN, DONE or ERR is ignored; no queueing.

## Timing
- Reset values:
  - `idle_o`=1.
  - `ap_start_o`, `ready_o`, `done_o`, `err_o`=0; `err_code_o`=00.
  - All counters 0.
- `start_i` high in cycle t → RUN, `ap_start_o`=1 and `idle_o`=0 in cycle t+1.
- Handshake in cycle t → counter value visible in cycle t+1.
- Last source handshake in cycle t:
  - out counter reaches len in t+1 and the FSM moves to DONE.
  - `done_o`=1 in t+2.
  - IDLE with `idle_o`=1 in t+3.
- Enabled sink/source with length 0, or all channels disabled: start in t → `done_o` in t+2.
- `ready_o` is a registered-count compare: high the cycle after the final sink handshake, and `ap_start_o` drops in that same cycle.
- Watchdog with `timeout_i`=T: with no handshakes after RUN entry, ERR is entered such that `err_o`=1 in cycle T+1 after entry.
- Counters never wrap: the maximum length is 2^CNT_W−1, and overflow is caught before increment.
- Async reset mid-job immediately forces all reset values.

## Structure
- Package `hls_stream_engine_pkg`: state enum, error-code constants (`ERR_TIMEOUT`, `ERR_OVERFLOW`), default widths.
- Sub-module `hls_stream_cnt`, instantiated N_IN+N_OUT times via generate. It contains one channel's counter, done compare, overflow detect and length/enable capture registers.
- Top level contains the FSM, watchdog, reductions and output logic.

## Test plan
- N_IN=2, N_OUT=1, lens {4,4}/{2}, full-rate handshakes → `ap_start_o` drops after 4th sink beat; `done_o` one pulse 2 cycles after 2nd out beat; `idle_o` returns.
- `in_en_i`=2'b10, len0=0, len1=3, out len 1 → only ch1 counts; ready after 3 beats; done as above.
- Out len 2, three out handshakes → `err_o`=1, `err_code_o`=10, cnt held at 2; `clear_i` → IDLE, all counters 0.
- `timeout_i`=5, no handshakes after start → `err_code_o`=01 at 6th RUN cycle; `start_i` ignored until clear.
- `start_i` and `clear_i` in same cycle, then `start_i` during RUN → remains IDLE; RUN job unaffected and counters continue.
- `rst_ni` low mid-RUN with cnt=3 → immediately counters 0, `idle_o`=1, `done_o` never pulses.
